// File: rtl/register_file.sv
// register_file: 32-entry general-purpose register file feeding the ALU.
// Two combinational read ports supply operands A and B. One clocked write port
// takes the write-back value. Register 0 always reads zero. With BYPASS=1, a
// value being written in the current cycle is forwarded to a matching read port.
// DbgData always shows the stored array value and is never forwarded.

module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] DbgData
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Index 0 has no storage; it is decoded to zero on every read path.
    logic [DATA_W-1:0] regs [1:DEPTH-1];

    // A write takes effect at the edge only when it is not suppressed by
    // reset and does not target the hard-wired zero register. The same
    // condition qualifies same-cycle forwarding.
    logic write_hit;

    // Qualify the write port once so storage and forwarding agree.
    always_comb begin
        write_hit = !Reset && RegWrite && (WriteRegister != '0);
    end

    // Register array: synchronous clear has priority over a write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: This memory is reset deliberately. Every register must
            // read zero after reset, so each entry is a flop with a clear.
            // Do not copy this pattern into RAM macros that cannot reset.
            for (int i = 1; i < DEPTH; i++) begin
                // NOTE: Sequential state uses non-blocking assignments only.
                // Other processes then read the pre-edge value.
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    // Read port 1 (ALU operand A): zero register, optional forward, then array.
    always_comb begin
        // NOTE: Assign the default first. Every path is then covered and no
        // latch is inferred.
        ReadData1 = '0;
        if (ReadRegister1 != '0) begin
            if (BYPASS && write_hit && (WriteRegister == ReadRegister1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = regs[ReadRegister1];
            end
        end
    end

    // Read port 2 (ALU operand B): same decode as port 1, fully independent.
    always_comb begin
        ReadData2 = '0;
        if (ReadRegister2 != '0) begin
            if (BYPASS && write_hit && (WriteRegister == ReadRegister2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = regs[ReadRegister2];
            end
        end
    end

    // Debug port: array contents only, so it shows committed state.
    always_comb begin
        DbgData = '0;
        if (DbgAddr != '0) begin
            DbgData = regs[DbgAddr];
        end
    end

endmodule
